// File: rtl/logic_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// logic_sched_pkg
// Shared definitions for the logic scheduler slice.
//   NREQ     : number of requesters served by one shared logic unit
//   op_e     : 2-bit opcode encoding of the logic unit
//   state_e  : scheduler FSM state encoding
// ---------------------------------------------------------------------------
package logic_sched_pkg;

    localparam int NREQ = 4;
    localparam int OPW  = 2;

    typedef enum logic [OPW-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_scheduler_if.sv
// ---------------------------------------------------------------------------
// logic_sched_if
// Requester-side bundle of the logic scheduler.
//   REQ    : per-requester request level (held until matching ACK bit)
//   OP     : per-requester 2-bit opcode, requester i at OP[2i +: 2]
//   A, B   : per-requester operands, requester i at [W*i +: W]
//   GNT    : one-hot grant of the operation in flight
//   ACK    : one-hot, one-cycle completion pulse
//   RESULT : result of the completed operation
//   VALID  : one-cycle pulse coincident with ACK
//   BUSY   : scheduler is not idle
// Modports: master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface logic_sched_if #(
    parameter int W    = 8,
    parameter int NREQ = logic_sched_pkg::NREQ
);
    logic [NREQ-1:0]   REQ;
    logic [2*NREQ-1:0] OP;
    logic [W*NREQ-1:0] A;
    logic [W*NREQ-1:0] B;
    logic [NREQ-1:0]   GNT;
    logic [NREQ-1:0]   ACK;
    logic [W-1:0]      RESULT;
    logic              VALID;
    logic              BUSY;

    modport master (
        output REQ, OP, A, B,
        input  GNT, ACK, RESULT, VALID, BUSY
    );

    modport slave (
        input  REQ, OP, A, B,
        output GNT, ACK, RESULT, VALID, BUSY
    );
endinterface

// File: rtl/logic_scheduler_unit.sv
// ---------------------------------------------------------------------------
// logic_unit
// Registered bitwise logic unit, one cycle latency.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset, clears OUT1
//   OP   : opcode (AND / OR / XOR / NOR)
//   IN1  : first operand
//   IN2  : second operand
//   OUT1 : registered result of the previous cycle's inputs
// ---------------------------------------------------------------------------
module logic_unit #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [1:0]   OP,
    input  logic [W-1:0] IN1,
    input  logic [W-1:0] IN2,
    output logic [W-1:0] OUT1
);
    import logic_sched_pkg::*;

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;

    always_comb begin
        out_d = '0;
        case (op_e'(OP))
            OP_AND:  out_d = IN1 & IN2;
            OP_OR:   out_d = IN1 | IN2;
            OP_XOR:  out_d = IN1 ^ IN2;
            OP_NOR:  out_d = ~(IN1 | IN2);
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT1 = out_q;

endmodule

// File: rtl/logic_scheduler.sv
// ---------------------------------------------------------------------------
// logic_scheduler
// Shares one registered logic unit among NREQ requesters. A round-robin
// pick in IDLE grants one requester, ISSUE feeds its opcode/operands to the
// unit, CAPTURE registers the unit output onto RESULT and pulses VALID/ACK.
// One operation completes every three cycles at most.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : logic_sched_if slave port (REQ/OP/A/B in, GNT/ACK/RESULT/VALID/BUSY out)
// ---------------------------------------------------------------------------
module logic_scheduler #(
    parameter int W    = 8,
    parameter int NREQ = logic_sched_pkg::NREQ
) (
    input  logic          CLK,
    input  logic          RST,
    logic_sched_if.slave  bus
);
    import logic_sched_pkg::*;

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [W-1:0]      result_q, result_d;

    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    logic [NREQ-1:0]   pick_onehot;

    logic [1:0]        unit_op;
    logic [W-1:0]      unit_in1;
    logic [W-1:0]      unit_in2;
    logic [W-1:0]      unit_out;

    // Round-robin pick: scan offsets from the far end down to 0 so the
    // last hit is the requester closest to ptr_q in wrap-around order.
    always_comb begin
        int cand;
        cand       = 0;
        pick_idx   = '0;
        pick_found = |bus.REQ;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (bus.REQ[cand]) begin
                pick_idx = IDXW'(cand);
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == IDXW'(gi));
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        valid_d  = 1'b0;
        result_d = result_q;
        unit_op  = '0;
        unit_in1 = '0;
        unit_in2 = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = ISSUE;
                end else begin
                    gnt_d   = '0;
                end
            end
            ISSUE: begin
                // Operands are only routed here, so the unit register holds
                // exactly the ISSUE-cycle inputs when CAPTURE reads it.
                unit_op  = bus.OP[2*int'(idx_q) +: 2];
                unit_in1 = bus.A[W*int'(idx_q) +: W];
                unit_in2 = bus.B[W*int'(idx_q) +: W];
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                result_d = unit_out;
                valid_d  = 1'b1;
                ack_d    = gnt_q;
                ptr_d    = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                gnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ack_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    logic_unit #(.W(W)) u_unit (
        .CLK  (CLK),
        .RST  (RST),
        .OP   (unit_op),
        .IN1  (unit_in1),
        .IN2  (unit_in2),
        .OUT1 (unit_out)
    );

    assign bus.GNT    = gnt_q;
    assign bus.ACK    = ack_q;
    assign bus.RESULT = result_q;
    assign bus.VALID  = valid_q;
    assign bus.BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_logic_scheduler.sv
// ---------------------------------------------------------------------------
// tb_logic_scheduler
// Directed bench for logic_scheduler (W=8, NREQ=4): a vector table of
// single-requester operations plus hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_logic_scheduler;

    logic clk;
    logic rst;

    logic_sched_if #(.W(8), .NREQ(4)) bus ();

    logic_scheduler #(.W(8), .NREQ(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct {
        string      name;
        int         idx;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    int         ord31[5];
    logic [7:0] ex31[5];
    int         ord35[3];
    logic [7:0] ex35[3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("pass %s: %0h", nm, act);
        end
    endtask

    // One isolated operation: grant, CAPTURE with no ACK yet, completion,
    // then RESULT held while an unrelated operand change happens in IDLE.
    task automatic run_single(input vec_t v);
        bus.OP = 8'($urandom);
        bus.A  = 32'($urandom);
        bus.B  = 32'($urandom);
        bus.OP[2*v.idx +: 2] = v.op;
        bus.A[8*v.idx +: 8]  = v.a;
        bus.B[8*v.idx +: 8]  = v.b;
        bus.REQ = 4'(1 << v.idx);
        tick;
        check({v.name, "_gnt"}, 32'(bus.GNT), 32'(1) << v.idx);
        check({v.name, "_busy"}, 32'(bus.BUSY), 32'd1);
        tick;
        check({v.name, "_ack_early"}, 32'(bus.ACK), 32'd0);
        tick;
        check({v.name, "_ack"}, 32'(bus.ACK), 32'(1) << v.idx);
        check({v.name, "_valid"}, 32'(bus.VALID), 32'd1);
        check({v.name, "_result"}, 32'(bus.RESULT), 32'(v.exp));
        check({v.name, "_gnt_clr"}, 32'(bus.GNT), 32'd0);
        bus.REQ = '0;
        bus.A   = ~bus.A;
        tick;
        check({v.name, "_valid_off"}, 32'(bus.VALID), 32'd0);
        check({v.name, "_hold"}, 32'(bus.RESULT), 32'(v.exp));
    endtask

    // Waits (bounded) for the next VALID pulse and checks spacing, ACK, RESULT.
    task automatic expect_op(input string nm, input int idx, input logic [7:0] exp);
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (bus.VALID !== 1'b1 && n < 8);
        check({nm, "_interval"}, 32'(n), 32'd3);
        check({nm, "_ack"}, 32'(bus.ACK), 32'(1) << idx);
        check({nm, "_result"}, 32'(bus.RESULT), 32'(exp));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst     = 1'b1;
        bus.REQ = '0;
        bus.OP  = '0;
        bus.A   = '0;
        bus.B   = '0;

        vecs[0] = '{"or_r0",   0, 2'b01, 8'hF0, 8'h0F, 8'hFF};
        vecs[1] = '{"nor_r2",  2, 2'b11, 8'hAA, 8'h00, 8'h55};
        vecs[2] = '{"and_r2",  2, 2'b00, 8'hAA, 8'h0F, 8'h0A};
        vecs[3] = '{"xor_r1",  1, 2'b10, 8'h3C, 8'hFF, 8'hC3};
        vecs[4] = '{"nor_r3",  3, 2'b11, 8'h0F, 8'hF0, 8'h00};
        vecs[5] = '{"and_r3",  3, 2'b00, 8'hFF, 8'hFF, 8'hFF};

        ord31 = '{0, 1, 2, 3, 0};
        ex31  = '{8'hED, 8'h3B, 8'hA6, 8'h78, 8'hED};
        ord35 = '{0, 3, 0};
        ex35  = '{8'h3C, 8'h42, 8'h3C};

        tick;
        tick;
        check("rst_gnt", 32'(bus.GNT), 32'd0);
        check("rst_ack", 32'(bus.ACK), 32'd0);
        check("rst_valid", 32'(bus.VALID), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_result", 32'(bus.RESULT), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_single(vecs[i]);
        end

        // All four requesting XOR, held: strict rotation, one result per 3 cycles.
        do_reset;
        bus.OP  = 8'b10101010;
        bus.A   = {8'h78, 8'h56, 8'h34, 8'h12};
        bus.B   = {8'h00, 8'hF0, 8'h0F, 8'hFF};
        bus.REQ = 4'hF;
        for (int k = 0; k < 5; k++) begin
            expect_op($sformatf("rr%0d", k), ord31[k], ex31[k]);
        end
        bus.REQ = '0;
        tick;
        tick;

        // Requester 0 drops REQ in ISSUE and changes A0 in CAPTURE.
        do_reset;
        bus.OP  = 8'h01;
        bus.A   = 32'h00000081;
        bus.B   = 32'h00000018;
        bus.REQ = 4'b0001;
        tick;
        check("drop_gnt", 32'(bus.GNT), 32'd1);
        bus.REQ = '0;
        tick;
        bus.A = '0;
        bus.B = '0;
        bus.OP = '0;
        tick;
        check("drop_ack", 32'(bus.ACK), 32'd1);
        check("drop_result", 32'(bus.RESULT), 32'h99);
        tick;
        check("drop_idle_busy", 32'(bus.BUSY), 32'd0);

        // Reset during ISSUE aborts; afterwards search starts at 0 again.
        bus.OP[5:4]   = 2'b10;
        bus.A[23:16]  = 8'hFF;
        bus.B[23:16]  = 8'h0F;
        bus.REQ       = 4'b0100;
        tick;
        check("abort_gnt", 32'(bus.GNT), 32'h4);
        check("abort_busy", 32'(bus.BUSY), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_gnt0", 32'(bus.GNT), 32'd0);
        check("abort_busy0", 32'(bus.BUSY), 32'd0);
        check("abort_result0", 32'(bus.RESULT), 32'd0);
        tick;
        check("abort_ack0", 32'(bus.ACK), 32'd0);
        check("abort_valid0", 32'(bus.VALID), 32'd0);
        tick;
        rst = 1'b0;
        bus.OP[1:0] = 2'b00;
        bus.A[7:0]  = 8'hF3;
        bus.B[7:0]  = 8'h3F;
        bus.REQ     = 4'b0101;
        tick;
        check("post_rst_gnt", 32'(bus.GNT), 32'd1);
        tick;
        tick;
        check("post_rst_ack", 32'(bus.ACK), 32'd1);
        check("post_rst_result", 32'(bus.RESULT), 32'h33);
        bus.REQ = '0;
        tick;

        // Requesters 0 and 3 held: 0, 3, then wrap back to 0.
        do_reset;
        bus.OP       = '0;
        bus.OP[1:0]  = 2'b10;
        bus.OP[7:6]  = 2'b01;
        bus.A        = {8'h40, 8'h00, 8'h00, 8'h0F};
        bus.B        = {8'h02, 8'h00, 8'h00, 8'h33};
        bus.REQ      = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            expect_op($sformatf("wrap%0d", k), ord35[k], ex35[k]);
        end
        bus.REQ = '0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/logic_scheduler.md
LOGIC_SCHEDULER -- requirements
Module: logic_scheduler

Interface
REQ-001 Parameter W, 8, operand/result width in bits (1..32).
REQ-002 Parameter NREQ, 4, number of requesters (fixed at 4 in this release).
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ  input  NREQ  per-requester request level, held high until matching ACK bit.
REQ-006 OP  input  2*NREQ  per-requester opcode, 2 bits each: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 A  input  W*NREQ  per-requester first operand.
REQ-008 B  input  W*NREQ  per-requester second operand.
REQ-009 GNT  output  NREQ  one-hot grant, all-zero when no operation is in flight.
REQ-010 ACK  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 RESULT  output  W  result of the completed operation, valid when VALID=1.
REQ-012 VALID  output  1  one-cycle pulse coincident with ACK.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL share one registered logic unit (1-cycle latency) among NREQ requesters using an FSM with states IDLE, ISSUE, CAPTURE.
REQ-015 IDLE: if any REQ bit is high, the block SHALL select one requester round-robin, starting the search at index PTR and wrapping from NREQ-1 to 0, set GNT to that index and go to ISSUE; otherwise remain in IDLE with GNT=0.
REQ-016 ISSUE: the block SHALL route the granted requester's OP, A and B to the logic unit, which registers the result at the end of this cycle; next state CAPTURE.
REQ-017 CAPTURE: the block SHALL drive RESULT from the unit output, pulse VALID and ACK[granted] for exactly one cycle, set PTR to (granted+1) mod NREQ, clear GNT, and go to IDLE.
REQ-018 Latency SHALL be exactly 3 cycles from the rising edge at which REQ is sampled in IDLE to the ACK pulse; maximum throughput SHALL be one operation per 3 cycles.
REQ-019 RESULT SHALL hold its last value outside CAPTURE; VALID and ACK SHALL be 0 outside CAPTURE.
REQ-020 Operands and opcode SHALL be sampled only in ISSUE; changes in other states SHALL not affect the result.
REQ-021 If the granted requester drops REQ after the grant, the operation SHALL still complete and ACK SHALL still pulse.
REQ-022 A requester whose REQ stays high after its ACK SHALL be treated as a new request and SHALL be served again only after all other pending requesters (round-robin fairness).
REQ-023 Simultaneous requests SHALL be served in the order PTR, PTR+1, ... mod NREQ; no requester SHALL wait more than NREQ-1 operations.
REQ-024 Logic results SHALL be bitwise over W bits; NOR SHALL be the bitwise inverse of OR.

Reset
REQ-025 While RST=1, the block SHALL force state IDLE, PTR=0, GNT=0, ACK=0, VALID=0, BUSY=0, RESULT=0, and the logic unit register to 0, independent of CLK.
REQ-026 A reset asserted during ISSUE or CAPTURE SHALL abort the operation with no ACK pulse; after release, the block SHALL be in IDLE with the first grant searched from index 0.

Structure
REQ-027 Opcode constants (OP_AND, OP_OR, OP_XOR, OP_NOR), the FSM state encoding and NREQ SHALL reside in shared package logic_sched_pkg.
REQ-028 The registered logic unit SHALL be a separate sub-module, logic_unit (ports CLK, RST, OP, IN1, IN2, OUT1; 1-cycle latency; asynchronous reset to 0).
REQ-029 The round-robin pick SHALL be combinational from REQ and PTR; all outputs SHALL be registered.

Verification
REQ-030 W=8; reset, then REQ=0001, OP0=01, A0=0xF0, B0=0x0F -> GNT=0001 one cycle after sampling, ACK=0001, VALID=1, RESULT=0xFF exactly 3 cycles after sampling.
REQ-031 REQ=1111 held; all four OPs set to 10 with distinct operands -> ACKs in order 0,1,2,3,0; each RESULT equals A XOR B; VALID pulses every 3 cycles.
REQ-032 Requester 2 with OP=11, A=0xAA, B=0x00 -> RESULT=0x55; OP=00, A=0xAA, B=0x0F -> RESULT=0x0A.
REQ-033 REQ0 granted, REQ0 dropped during ISSUE -> ACK0 still pulses, RESULT correct; A0 changed during CAPTURE -> RESULT unaffected.
REQ-034 RST asserted during ISSUE with REQ=0100 -> GNT, ACK, VALID, BUSY, RESULT go 0 immediately with no ACK; after release with REQ=0101 -> requester 0 granted first.
REQ-035 After ACK to requester 3 with REQ=1001 still high -> next grant goes to requester 0 (pointer wrap).
